sm_rd_sched: RTL and testbench

Burst read scheduler for the byte-rotating select datapath. It accepts read-burst requests (start word address, beat count, byte rotation), drives BRAM port B enable/address and the select module's `SM_EN`/`Sel`, and presents each rotated 32-bit word downstream under a valid/ready handshake. It sits between the request source and the BRAM port B → select-module path. The select module's active-high `rst` is driven by the parent as `~rst`.

---
 rtl/sm_rd_sched_pkg.sv | 18 +
 rtl/sm_burst_cnt.sv | 57 +++++
 rtl/sm_rd_sched.sv | 100 ++++++++++
 tb/tb_sm_rd_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sm_rd_sched_pkg.sv
// Shared definitions for the burst read scheduler: select width, FSM state encodings, default widths.
// The SM_RD_SCHED_WRAP_EN build macro is consumed by sm_burst_cnt.
`ifndef SELECT
`define SELECT 1:0
`endif

package sm_rd_sched_pkg;

  localparam int SM_RD_SCHED_ADDR_W = 10;
  localparam int SM_RD_SCHED_LEN_W  = 8;

  typedef enum logic [1:0] {
    SM_RD_SCHED_IDLE   = 2'd0,
    SM_RD_SCHED_FETCH  = 2'd1,
    SM_RD_SCHED_STREAM = 2'd2
  } sm_rd_sched_state_e;

endpackage

// File: rtl/sm_burst_cnt.sv
// Address register and remaining-beat counter for one read burst.
// SM_RD_SCHED_WRAP_EN defined: bursts wrap past the top of memory; undefined: length is clamped at the top.
module sm_burst_cnt
  import sm_rd_sched_pkg::*;
#(
  parameter int ADDR_W = SM_RD_SCHED_ADDR_W,
  parameter int LEN_W  = SM_RD_SCHED_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              adv,
  input  logic              dec,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              trunc
);

  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] load_cnt;

`ifdef SM_RD_SCHED_WRAP_EN
  assign trunc    = 1'b0;
  assign load_cnt = len;
`else
  // Wide enough that start_addr + len cannot overflow before the compare.
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

  logic [SUM_W-1:0] end_addr;
  logic [SUM_W-1:0] room;

  assign end_addr = SUM_W'(start_addr) + SUM_W'(len);
  assign room     = SUM_W'({ADDR_W{1'b1}}) - SUM_W'(start_addr);
  assign trunc    = end_addr > SUM_W'({ADDR_W{1'b1}});
  // room < len whenever trunc is set, so the narrowing cannot lose bits.
  assign load_cnt = trunc ? LEN_W'(room) : len;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= start_addr;
      cnt  <= load_cnt;
    end else begin
      if (adv) addr <= addr + 1'b1;
      if (dec && cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/sm_rd_sched.sv
// Burst read scheduler: drives BRAM port B and the byte-rotating select module, streams beats under valid/ready.
// Build macro SM_RD_SCHED_WRAP_EN selects wrap-around bursts instead of clamping with an err pulse.
module sm_rd_sched
  import sm_rd_sched_pkg::*;
#(
  parameter int ADDR_W = SM_RD_SCHED_ADDR_W,
  parameter int LEN_W  = SM_RD_SCHED_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [`SELECT]    req_sel,
  output logic              EN_B,
  output logic [ADDR_W-1:0] ADDR_B,
  output logic              SM_EN,
  output logic [`SELECT]    Sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              err
);

  sm_rd_sched_state_e state;
  logic [`SELECT]     sel_q;
  logic               load;
  logic               adv;
  logic               dec;
  logic               last;
  logic               trunc;

  assign load = (state == SM_RD_SCHED_IDLE) && req_valid && req_ready;
  assign dec  = (state == SM_RD_SCHED_STREAM) && out_ready && !last;
  // The address register always points at the next word to fetch, so it
  // advances on the FETCH cycle and on every non-final handshake.
  assign adv  = (state == SM_RD_SCHED_FETCH) || dec;

  sm_burst_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .start_addr (req_addr),
    .len        (req_len),
    .adv        (adv),
    .dec        (dec),
    .addr       (ADDR_B),
    .last       (last),
    .trunc      (trunc)
  );

  assign EN_B     = adv;
  assign out_last = out_valid && last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SM_RD_SCHED_IDLE;
      req_ready <= 1'b0;
      SM_EN     <= 1'b0;
      out_valid <= 1'b0;
      Sel       <= '0;
      sel_q     <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        SM_RD_SCHED_IDLE: begin
          req_ready <= 1'b1;
          if (load) begin
            sel_q     <= req_sel;
            err       <= trunc;
            req_ready <= 1'b0;
            state     <= SM_RD_SCHED_FETCH;
          end
        end
        SM_RD_SCHED_FETCH: begin
          SM_EN     <= 1'b1;
          out_valid <= 1'b1;
          Sel       <= sel_q;
          state     <= SM_RD_SCHED_STREAM;
        end
        SM_RD_SCHED_STREAM: begin
          if (out_ready && last) begin
            SM_EN     <= 1'b0;
            out_valid <= 1'b0;
            Sel       <= '0;
            req_ready <= 1'b1;
            state     <= SM_RD_SCHED_IDLE;
          end
        end
        default: state <= SM_RD_SCHED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_rd_sched.sv
// Self-checking bench for sm_rd_sched: directed bursts plus random bursts against a queue-based reference model.
// Expectations follow SM_RD_SCHED_WRAP_EN when it is defined for the build.
`ifndef SELECT
`define SELECT 1:0
`endif

module tb_sm_rd_sched;

  localparam int ADDR_W   = 10;
  localparam int LEN_W    = 8;
  localparam int MAX_ADDR = (1 << ADDR_W) - 1;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [`SELECT]    req_sel;
  logic              EN_B;
  logic [ADDR_W-1:0] ADDR_B;
  logic              SM_EN;
  logic [`SELECT]    Sel;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              err;

  int checks   = 0;
  int failures = 0;

  sm_rd_sched #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_sel   (req_sel),
    .EN_B      (EN_B),
    .ADDR_B    (ADDR_B),
    .SM_EN     (SM_EN),
    .Sel       (Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_en_b"},      EN_B,      0);
    check({tag, "_addr_b"},    ADDR_B,    0);
    check({tag, "_sm_en"},     SM_EN,     0);
    check({tag, "_sel"},       Sel,       0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_err"},       err,       0);
  endtask

  // Entered just after a rising edge of a cycle in which the scheduler is idle and ready.
  // mode 0: out_ready always high; 1: three stall cycles on the second beat; 2: random out_ready.
  // hold keeps the same request asserted throughout the burst.
  task automatic run_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                           input logic [`SELECT] s, input int mode, input bit hold);
    logic [ADDR_W-1:0] addrs[$];
    int n;
    bit trunc;
    int idx;
    int guard;
    int stall;
    bit exp_en;

    trunc = 1'b0;
    n = int'(l) + 1;
`ifndef SM_RD_SCHED_WRAP_EN
    if (int'(a) + int'(l) > MAX_ADDR) begin
      trunc = 1'b1;
      n = MAX_ADDR - int'(a) + 1;
    end
`endif
    for (int i = 0; i < n; i++) addrs.push_back(ADDR_W'((int'(a) + i) % (MAX_ADDR + 1)));

    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_sel   = s;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_sm_en",     SM_EN,     0);
    check("idle_en_b",      EN_B,      0);

    next_cycle();
    req_valid = hold;
    @(negedge clk);
    check("fetch_en_b",      EN_B,      1);
    check("fetch_addr_b",    ADDR_B,    addrs[0]);
    check("fetch_err",       err,       trunc);
    check("fetch_out_valid", out_valid, 0);
    check("fetch_sm_en",     SM_EN,     0);
    check("fetch_req_ready", req_ready, 0);

    idx   = 0;
    guard = 0;
    stall = 0;
    while (idx < n && guard < 500) begin
      next_cycle();
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = !(idx == 1 && stall < 3);
          if (!out_ready) stall++;
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      exp_en = out_ready && (idx != n - 1);
      check("beat_out_valid", out_valid, 1);
      check("beat_sm_en",     SM_EN,     1);
      check("beat_sel",       Sel,       s);
      check("beat_out_last",  out_last,  (idx == n - 1));
      check("beat_req_ready", req_ready, 0);
      check("beat_err",       err,       0);
      check("beat_en_b",      EN_B,      exp_en);
      if (exp_en) check("beat_addr_b", ADDR_B, addrs[idx + 1]);
      if (out_ready) idx++;
      guard++;
    end
    check("burst_beats", idx, n);
    next_cycle();
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [LEN_W-1:0]  rl;
    logic [`SELECT]    rs;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_sel   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    next_cycle();

    run_burst(10'h010, 8'd3, 2'd2, 0, 1'b0);
    run_burst(10'h010, 8'd3, 2'd2, 1, 1'b0);
    run_burst(10'h055, 8'd0, 2'd1, 0, 1'b0);
    run_burst(10'h3FE, 8'd3, 2'd3, 0, 1'b0);
    run_burst(10'h200, 8'd2, 2'd1, 0, 1'b1);
    run_burst(10'h200, 8'd2, 2'd1, 0, 1'b0);

    // Reset during the second beat of a four-beat burst.
    req_valid = 1'b1;
    req_addr  = 10'h100;
    req_len   = 8'd3;
    req_sel   = 2'd1;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    check_reset_values("midburst_reset");
    rst = 1'b1;
    next_cycle();
    run_burst(10'h120, 8'd3, 2'd0, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) ra = ADDR_W'(MAX_ADDR - int'($urandom_range(0, 8)));
      else ra = ADDR_W'($urandom_range(0, MAX_ADDR));
      rl = LEN_W'($urandom_range(0, 15));
      rs = 2'($urandom_range(0, 3));
      run_burst(ra, rl, rs, 2, 1'b0);
    end

    @(negedge clk);
    check("final_req_ready", req_ready, 1);
    check("final_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
